// File: rtl/tx_arbiter_n_pkg.sv
// tx_arbiter_n_pkg -- definitions shared by the tx_arbiter_n block.
//   state_t     : arbiter FSM state encoding
//   clog2_min1  : ceil(log2(n)) clamped to a minimum of 1 bit, for index widths
package tx_arbiter_n_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2
   } state_t;

   // A single source still needs a 1-bit index so that cur_src is a real port.
   function automatic int clog2_min1(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/tx_arbiter_n_rr_priority_encoder.sv
// rr_priority_encoder -- combinational round-robin selector.
// Picks the lowest-numbered requester at or above ptr; if none, wraps and
// picks the lowest-numbered requester below ptr.
//   req   in  [N-1:0]   request vector
//   ptr   in  [IW-1:0]  index with highest priority this round
//   grant out [IW-1:0]  selected index (0 when nothing requests)
//   valid out           at least one request present
module rr_priority_encoder #(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] grant,
   output logic          valid
);

   always_comb begin
      grant = '0;
      valid = 1'b0;
      // upper segment first: indices ptr..N-1
      for (int i = 0; i < N; i++) begin
         if (!valid && req[i] && (IW'(i) >= ptr)) begin
            valid = 1'b1;
            grant = IW'(i);
         end
      end
      // wrapped segment: indices 0..ptr-1
      for (int i = 0; i < N; i++) begin
         if (!valid && req[i] && (IW'(i) < ptr)) begin
            valid = 1'b1;
            grant = IW'(i);
         end
      end
   end

endmodule

// File: rtl/tx_arbiter_n.sv
// tx_arbiter_n -- round-robin frame arbiter feeding a single FT245-style
// transmit port. A granted source keeps the port until its eof word is
// accepted; optionally each frame is prefixed with a source-ID header word.
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   src_data  in   packed source words, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_rdy   in   per-source word valid
//   src_eof   in   per-source last-word-of-frame flag
//   src_ack   out  per-source one-cycle consume pulse
//   tx_data   out  word to downstream
//   tx_rdy    out  tx_data valid
//   tx_ack    in   downstream consumed tx_data
//   busy      out  a frame is granted
//   cur_src   out  index of granted (or last granted) source
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no grant; arbitrate among src_rdy starting at rr_ptr
// ST_HEADER  | presenting HEADER_BASE + cur_src, waiting for tx_ack
// ST_PAYLOAD | passing cur_src's words through until its eof word is acked
module tx_arbiter_n
   import tx_arbiter_n_pkg::*;
#(
   parameter int                    SOURCES     = 3,
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    HEADER_EN   = 1,
   parameter logic [DATA_WIDTH-1:0] HEADER_BASE = 8'hF0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [SOURCES*DATA_WIDTH-1:0]    src_data,
   input  logic [SOURCES-1:0]               src_rdy,
   input  logic [SOURCES-1:0]               src_eof,
   output logic [SOURCES-1:0]               src_ack,
   output logic [DATA_WIDTH-1:0]            tx_data,
   output logic                             tx_rdy,
   input  logic                             tx_ack,
   output logic                             busy,
   output logic [clog2_min1(SOURCES)-1:0]   cur_src
);

   localparam int IW = clog2_min1(SOURCES);

   state_t          state, state_nxt;
   logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
   logic [IW-1:0]   cur_src_nxt;

   logic [IW-1:0]   gnt_idx;
   logic            gnt_valid;

   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_rdy;
   logic                  sel_eof;
   logic                  take;

   rr_priority_encoder #(
      .N  (SOURCES),
      .IW (IW)
   ) u_rr (
      .req   (src_rdy),
      .ptr   (rr_ptr),
      .grant (gnt_idx),
      .valid (gnt_valid)
   );

   // mux the granted source's signals; out-of-range cur_src values select nothing
   always_comb begin
      sel_data = '0;
      sel_rdy  = 1'b0;
      sel_eof  = 1'b0;
      for (int i = 0; i < SOURCES; i++) begin
         if (cur_src == IW'(i)) begin
            sel_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_rdy  = src_rdy[i];
            sel_eof  = src_eof[i];
         end
      end
   end

   // a payload word is consumed only when it is valid and accepted;
   // reset wins so an abandoned frame never sees its pending word acked
   assign take = (state == ST_PAYLOAD) && sel_rdy && tx_ack && !rst;

   always_comb begin
      state_nxt   = state;
      rr_ptr_nxt  = rr_ptr;
      cur_src_nxt = cur_src;
      tx_data     = '0;
      tx_rdy      = 1'b0;
      src_ack     = '0;

      case (state)
         ST_IDLE: begin
            if (gnt_valid) begin
               cur_src_nxt = gnt_idx;
               state_nxt   = (HEADER_EN != 0) ? ST_HEADER : ST_PAYLOAD;
            end
         end

         ST_HEADER: begin
            tx_data = HEADER_BASE + DATA_WIDTH'(cur_src);
            tx_rdy  = 1'b1;
            if (tx_ack) state_nxt = ST_PAYLOAD;
         end

         ST_PAYLOAD: begin
            tx_data = sel_data;
            tx_rdy  = sel_rdy;
            for (int i = 0; i < SOURCES; i++) begin
               src_ack[i] = take && (cur_src == IW'(i));
            end
            if (take && sel_eof) begin
               state_nxt  = ST_IDLE;
               rr_ptr_nxt = (cur_src == IW'(SOURCES - 1)) ? '0 : cur_src + IW'(1);
            end
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         rr_ptr  <= '0;
         cur_src <= '0;
      end else begin
         state   <= state_nxt;
         rr_ptr  <= rr_ptr_nxt;
         cur_src <= cur_src_nxt;
      end
   end

endmodule

// File: tb/tb_tx_arbiter_n.sv
// tb_tx_arbiter_n -- two DUTs (with and without header words) driven by the
// same source/ack inputs and checked every cycle against a frame-level model,
// plus directed stream checks for the headline scenarios.
module tb_tx_arbiter_n;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  sdat [3];
   logic [2:0]  srdy, seof;
   logic        tx_ack;
   logic [23:0] src_data;

   logic [2:0]  src_ack_a, src_ack_b;
   logic [7:0]  tx_data_a, tx_data_b;
   logic        tx_rdy_a, tx_rdy_b, busy_a, busy_b;
   logic [1:0]  cur_src_a, cur_src_b;

   assign src_data = {sdat[2], sdat[1], sdat[0]};

   always #5 clk = ~clk;

   tx_arbiter_n #(.SOURCES(3), .DATA_WIDTH(8), .HEADER_EN(1), .HEADER_BASE(8'hF0)) u_dut_a (
      .clk(clk), .rst(rst), .src_data(src_data), .src_rdy(srdy), .src_eof(seof),
      .src_ack(src_ack_a), .tx_data(tx_data_a), .tx_rdy(tx_rdy_a), .tx_ack(tx_ack),
      .busy(busy_a), .cur_src(cur_src_a));

   tx_arbiter_n #(.SOURCES(3), .DATA_WIDTH(8), .HEADER_EN(0), .HEADER_BASE(8'hF0)) u_dut_b (
      .clk(clk), .rst(rst), .src_data(src_data), .src_rdy(srdy), .src_eof(seof),
      .src_ack(src_ack_b), .tx_data(tx_data_b), .tx_rdy(tx_rdy_b), .tx_ack(tx_ack),
      .busy(busy_b), .cur_src(cur_src_b));

   int errors = 0;
   int checks = 0;

   // frame-level reference model, one per DUT: owner of the port (-1 = none),
   // whether its header went out, next round-robin start, last granted index
   int       own   [2] = '{-1, -1};
   int       mptr  [2] = '{0, 0};
   int       mlast [2] = '{0, 0};
   bit       mhs   [2] = '{1'b0, 1'b0};
   bit       hen   [2] = '{1'b1, 1'b0};
   logic [2:0] exp_ack [2];

   // frame-driven sources (advance on model-predicted acks of DUT A)
   bit       use_frames = 1'b0;
   int       flen [3], fstart [3], wi [3];
   bit       drop [3];
   logic [7:0] acc_q [$];
   logic [7:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic init_frames();
      for (int i = 0; i < 3; i++) begin
         flen[i] = 0; fstart[i] = 0; wi[i] = 0; drop[i] = 1'b0;
      end
      acc_q.delete();
   endtask

   task automatic drive(input int c);
      if (use_frames) begin
         for (int i = 0; i < 3; i++) begin
            srdy[i] = (c >= fstart[i]) && (wi[i] < flen[i]) && !drop[i];
            sdat[i] = {4'(i), 4'(wi[i] + 1)};
            seof[i] = (wi[i] == flen[i] - 1);
         end
      end
   endtask

   task automatic settle_check();
      logic       e_rdy, e_busy, o_rdy, o_busy;
      logic [7:0] e_dat, o_dat;
      logic [2:0] o_ack;
      logic [1:0] o_cur;
      bit         chkdat;
      #1;
      for (int d = 0; d < 2; d++) begin
         e_busy = (own[d] >= 0);
         e_rdy  = 1'b0;
         e_dat  = '0;
         exp_ack[d] = '0;
         chkdat = 1'b0;
         if (own[d] >= 0) begin
            chkdat = 1'b1;
            if (hen[d] && !mhs[d]) begin
               e_rdy = 1'b1;
               e_dat = 8'hF0 + 8'(own[d]);
            end else begin
               e_rdy = srdy[own[d]];
               e_dat = sdat[own[d]];
               if (tx_ack && srdy[own[d]] && !rst) exp_ack[d][own[d]] = 1'b1;
            end
         end
         o_rdy  = (d == 0) ? tx_rdy_a  : tx_rdy_b;
         o_busy = (d == 0) ? busy_a    : busy_b;
         o_dat  = (d == 0) ? tx_data_a : tx_data_b;
         o_ack  = (d == 0) ? src_ack_a : src_ack_b;
         o_cur  = (d == 0) ? cur_src_a : cur_src_b;
         chk($sformatf("dut%0d busy", d), 32'(o_busy), 32'(e_busy));
         chk($sformatf("dut%0d tx_rdy", d), 32'(o_rdy), 32'(e_rdy));
         chk($sformatf("dut%0d src_ack", d), 32'(o_ack), 32'(exp_ack[d]));
         chk($sformatf("dut%0d cur_src", d), 32'(o_cur), 32'(mlast[d]));
         if (chkdat) chk($sformatf("dut%0d tx_data", d), 32'(o_dat), 32'(e_dat));
         if (d == 0 && e_rdy && tx_ack && !rst) acc_q.push_back(tx_data_a);
      end
   endtask

   task automatic clock_adv();
      bit found;
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            own[d] = -1; mptr[d] = 0; mlast[d] = 0; mhs[d] = 1'b0;
         end else if (own[d] < 0) begin
            found = 1'b0;
            for (int k = 0; k < 3; k++) begin
               int i;
               i = (mptr[d] + k) % 3;
               if (!found && srdy[i]) begin
                  found = 1'b1; own[d] = i; mlast[d] = i; mhs[d] = 1'b0;
               end
            end
         end else if (hen[d] && !mhs[d]) begin
            if (tx_ack) mhs[d] = 1'b1;
         end else if (tx_ack && srdy[own[d]] && seof[own[d]]) begin
            mptr[d] = (own[d] + 1) % 3;
            own[d]  = -1;
         end
      end
      for (int i = 0; i < 3; i++) if (exp_ack[0][i]) wi[i]++;
      @(negedge clk);
   endtask

   task automatic reset_all();
      use_frames = 1'b0;
      rst = 1'b1; srdy = '0; seof = '0; tx_ack = 1'b0;
      settle_check();
      clock_adv();
      rst = 1'b0;
      init_frames();
   endtask

   task automatic chk_stream(input string tag);
      chk({tag, " len"}, 32'(acc_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
         chk($sformatf("%s word%0d", tag, i), 32'(acc_q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      int cnt [3];
      rst = 1'b1; srdy = '0; seof = '0; tx_ack = 1'b0;
      for (int i = 0; i < 3; i++) sdat[i] = '0;
      init_frames();
      @(posedge clk);
      @(negedge clk);

      // reset state
      reset_all();
      settle_check();
      chk("reset busy_a", 32'(busy_a), 32'd0);
      chk("reset tx_rdy_a", 32'(tx_rdy_a), 32'd0);
      chk("reset src_ack_a", 32'(src_ack_a), 32'd0);
      chk("reset cur_src_a", 32'(cur_src_a), 32'd0);
      clock_adv();

      // all three request single-word frames, tx_ack always high
      reset_all();
      srdy = 3'b111; seof = 3'b111; tx_ack = 1'b1;
      sdat[0] = 8'hA0; sdat[1] = 8'hA1; sdat[2] = 8'hA2;
      cnt = '{0, 0, 0};
      for (int c = 0; c < 9; c++) begin
         settle_check();
         for (int i = 0; i < 3; i++) cnt[i] += int'(src_ack_a[i]);
         clock_adv();
      end
      exp_q = '{8'hF0, 8'hA0, 8'hF1, 8'hA1, 8'hF2, 8'hA2};
      chk_stream("rr3");
      for (int i = 0; i < 3; i++) chk($sformatf("rr3 acks src%0d", i), 32'(cnt[i]), 32'd1);

      // source 1 four-word frame, source 0 joins from cycle 2 and must wait
      reset_all();
      use_frames = 1'b1; tx_ack = 1'b1;
      flen[1] = 4; flen[0] = 2; fstart[0] = 2;
      for (int c = 0; c < 14; c++) begin
         drive(c); settle_check(); clock_adv();
      end
      exp_q = '{8'hF1, 8'h11, 8'h12, 8'h13, 8'h14, 8'hF0, 8'h01, 8'h02};
      chk_stream("lock");

      // downstream stalls five cycles in payload
      reset_all();
      use_frames = 1'b1;
      flen[2] = 3;
      for (int c = 0; c < 12; c++) begin
         tx_ack = !(c >= 3 && c <= 7);
         drive(c); settle_check();
         if (c >= 3 && c <= 7) begin
            chk("stall tx_data", 32'(tx_data_a), 32'h22);
            chk("stall src_ack", 32'(src_ack_a), 32'd0);
         end
         clock_adv();
      end
      exp_q = '{8'hF2, 8'h21, 8'h22, 8'h23};
      chk_stream("stall");

      // reset on the second payload word's ack abandons the frame and rr_ptr
      reset_all();
      use_frames = 1'b1; tx_ack = 1'b1;
      flen[1] = 1; flen[2] = 4; fstart[2] = 3;
      for (int c = 0; c < 7; c++) begin
         rst = (c == 6);
         drive(c); settle_check();
         if (c == 6) chk("rst src_ack", 32'(src_ack_a), 32'd0);
         clock_adv();
      end
      rst = 1'b0; use_frames = 1'b0; srdy = '0; seof = '0;
      settle_check();
      chk("post-rst busy", 32'(busy_a), 32'd0);
      chk("post-rst tx_rdy", 32'(tx_rdy_a), 32'd0);
      clock_adv();
      srdy = 3'b111; seof = 3'b111;
      settle_check(); clock_adv();
      settle_check();
      chk("post-rst grant", 32'(cur_src_a), 32'd0);
      chk("post-rst header", 32'(tx_data_a), 32'hF0);
      clock_adv();

      // no-header DUT: rr_ptr=2 then requests 011 wrap to source 0
      reset_all();
      srdy = 3'b010; seof = 3'b010; sdat[1] = 8'h77; tx_ack = 1'b0;
      settle_check(); clock_adv();
      tx_ack = 1'b1;
      settle_check(); clock_adv();
      srdy = 3'b011; seof = 3'b000; sdat[0] = 8'h3C; tx_ack = 1'b0;
      settle_check(); clock_adv();
      settle_check();
      chk("wrap tx_rdy_b", 32'(tx_rdy_b), 32'd1);
      chk("wrap tx_data_b", 32'(tx_data_b), 32'h3C);
      chk("wrap cur_src_b", 32'(cur_src_b), 32'd0);
      clock_adv();

      // granted source drops src_rdy for three cycles mid-frame
      reset_all();
      use_frames = 1'b1; tx_ack = 1'b1;
      flen[0] = 5; flen[1] = 1; fstart[1] = 4;
      for (int c = 0; c < 14; c++) begin
         drop[0] = (c >= 4 && c <= 6);
         drive(c); settle_check();
         if (c >= 4 && c <= 6) begin
            chk("drop tx_rdy", 32'(tx_rdy_a), 32'd0);
            chk("drop busy", 32'(busy_a), 32'd1);
            chk("drop cur_src", 32'(cur_src_a), 32'd0);
         end
         clock_adv();
      end
      exp_q = '{8'hF0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hF1, 8'h11};
      chk_stream("drop");

      // random traffic against the model
      reset_all();
      for (int c = 0; c < 400; c++) begin
         srdy   = 3'($urandom);
         seof   = 3'($urandom);
         for (int i = 0; i < 3; i++) sdat[i] = 8'($urandom);
         tx_ack = ($urandom_range(0, 3) != 0);
         rst    = ($urandom_range(0, 39) == 0);
         settle_check(); clock_adv();
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tx_arbiter_n.md
TX_ARBITER_N -- requirements
Module: tx_arbiter_n

Interface
REQ-001 SHALL have parameter SOURCES, default 3, number of frame sources (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, width of every data word.
REQ-003 SHALL have parameter HEADER_EN, default 1; 1 = prefix each frame with one source-ID header word.
REQ-004 SHALL have parameter HEADER_BASE, default 8'hF0; header word value = HEADER_BASE + source index.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port src_data  input  SOURCES*DATA_WIDTH  packed source words; source i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port src_rdy  input  SOURCES  source i has a valid word.
REQ-009 SHALL have port src_eof  input  SOURCES  source i's current word is its frame's last word.
REQ-010 SHALL have port src_ack  output  SOURCES  one-cycle pulse: source i's word consumed.
REQ-011 SHALL have port tx_data  output  DATA_WIDTH  word to FT245 simple interface.
REQ-012 SHALL have port tx_rdy  output  1  tx_data valid.
REQ-013 SHALL have port tx_ack  input  1  downstream consumed tx_data this cycle.
REQ-014 SHALL have port busy  output  1  a frame is granted (state not IDLE).
REQ-015 SHALL have port cur_src  output  clog2(SOURCES) min 1  index of granted source.

Function
REQ-016 FSM SHALL have states IDLE, HEADER, PAYLOAD.
REQ-017 IDLE: tx_rdy=0, src_ack=0; if any src_rdy, grant first requesting index at or after rr_ptr (wrapping), register it in cur_src, go to HEADER (HEADER_EN=1) or PAYLOAD (HEADER_EN=0) next cycle.
REQ-018 HEADER: tx_data = HEADER_BASE + cur_src (mod 2^DATA_WIDTH), tx_rdy=1, src_ack all 0; on tx_ack go to PAYLOAD.
REQ-019 PAYLOAD: tx_data = src_data[cur_src], tx_rdy = src_rdy[cur_src], combinational pass-through, zero latency.
REQ-020 PAYLOAD: src_ack[cur_src] = tx_ack & src_rdy[cur_src]; every other src_ack bit 0.
REQ-021 PAYLOAD: on tx_ack & src_rdy[cur_src] & src_eof[cur_src], go to IDLE and set rr_ptr = cur_src+1, wrapping SOURCES-1 to 0.
REQ-022 Grant SHALL stay locked to cur_src until its eof word is acked; other requests wait, never interleave.
REQ-023 Granted source dropping src_rdy mid-frame: tx_rdy=0, state held, no timeout.
REQ-024 tx_ack while tx_rdy=0 SHALL be ignored; no state change, no src_ack.
REQ-025 Single-word frame (eof on first word) SHALL be legal: header + one word, then IDLE.
REQ-026 Arbitration grant latency SHALL be exactly 1 cycle from src_rdy rising in IDLE to tx_rdy=1.
REQ-027 SOURCES=1: rr_ptr constant 0, cur_src width 1, behaviour otherwise identical.
REQ-028 src_eof SHALL be ignored when src_rdy of that source is 0.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, rr_ptr=0, cur_src=0; tx_rdy, src_ack, busy = 0 next cycle.
REQ-030 Reset mid-frame SHALL abandon the frame without acking the pending word; rst has priority over tx_ack.

Structure
REQ-031 Shared package SHALL hold the state encoding constants and the clog2 function.
REQ-032 Round-robin selection SHALL be a sub-module rr_priority_encoder (request vector, pointer in; grant index, valid out), purely combinational.
REQ-033 Only state, rr_ptr and cur_src SHALL be registered; target 120-250 RTL lines.

Verification
REQ-034 SOURCES=3: src_rdy=3'b111 all eof on first word, tx_ack always 1 -> headers F0,F1,F2 in order, each followed by one payload word, 3 src_ack pulses.
REQ-035 Source 1 sends 4-word frame 0x11..0x14 while source 0 requests from cycle 2 -> stream F1,11,12,13,14,F0,...; no source-0 word before 0x14 acked.
REQ-036 tx_ack held 0 for 5 cycles during PAYLOAD -> tx_data stable, src_ack 0 throughout.
REQ-037 rst asserted on the cycle of the 2nd payload word's tx_ack -> no src_ack, next cycle busy=0, tx_rdy=0, rr_ptr=0.
REQ-038 HEADER_EN=0, rr_ptr=2, src_rdy=3'b011 -> cur_src=0 granted (wrap), first tx_data = source 0 word.
REQ-039 Granted source drops src_rdy 3 cycles mid-frame -> tx_rdy=0 those cycles, grant retained, frame resumes.
